// File: rtl/ram1_bus_sequencer_pkg.sv
// Shared types and sizing for the RAM1 bus sequencer.
package ram1_bus_sequencer_pkg;

    localparam int ADDR_W              = 16;
    localparam int DATA_W              = 16;
    localparam int CNT_W               = 4;
    localparam int WAIT_CYCLES_DEFAULT = 2;

    typedef enum logic [2:0] {
        IDLE,
        RD_SETUP,
        RD_WAIT,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        DONE
    } seqState_t;

endpackage

// File: rtl/ram1_wait_counter.sv
// Loadable down-counter timing the SRAM access wait phase; saturates at zero.
module ram1_wait_counter
    import ram1_bus_sequencer_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic             decrement,
    input  logic [CNT_W-1:0] loadValue,
    output logic             isZero
);

    logic [CNT_W-1:0] countReg;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            countReg <= '0;
        end else if (load) begin
            countReg <= loadValue;
        end else if (decrement && (countReg != '0)) begin
            countReg <= countReg - 1'b1;
        end
    end

    assign isZero = (countReg == '0);

endmodule

// File: rtl/ram1_bus_sequencer.sv
// Sequences single read/write accesses from the MEM stage onto the RAM1 async SRAM bus.
module ram1_bus_sequencer
    import ram1_bus_sequencer_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] dataIn,
    output logic [DATA_W-1:0] dataOut,
    output logic              memBusy,
    output logic              memDone,
    output logic              ram1EN,
    output logic              ram1OE,
    output logic              ram1WE,
    output logic [ADDR_W-1:0] ram1Addr,
    inout  wire  [DATA_W-1:0] ram1Data
);

    localparam logic [CNT_W-1:0] LOAD_VALUE = CNT_W'(WAIT_CYCLES - 1);

    seqState_t         stateReg, stateNext;
    logic [ADDR_W-1:0] addrReg;
    logic [DATA_W-1:0] wrDataReg;
    logic [DATA_W-1:0] dataOutReg;
    logic              cntLoad, cntDec, cntZero;
    logic              busDrive;
    logic              accept;

    assign accept = (stateReg == IDLE) && (memRead || memWrite);

    ram1_wait_counter uWaitCounter (
        .CLK       (CLK),
        .RST       (RST),
        .load      (cntLoad),
        .decrement (cntDec),
        .loadValue (LOAD_VALUE),
        .isZero    (cntZero)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // Request operands are frozen at acceptance so the pipeline may move on mid-access.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            addrReg    <= '0;
            wrDataReg  <= '0;
            dataOutReg <= '0;
        end else begin
            if (accept) begin
                addrReg   <= address;
                wrDataReg <= dataIn;
            end
            if ((stateReg == RD_WAIT) && cntZero) begin
                dataOutReg <= ram1Data;
            end
        end
    end

    always_comb begin
        stateNext = stateReg;
        cntLoad   = 1'b0;
        cntDec    = 1'b0;
        ram1EN    = 1'b1;
        ram1OE    = 1'b1;
        ram1WE    = 1'b1;
        busDrive  = 1'b0;
        memDone   = 1'b0;
        ram1Addr  = addrReg;
        case (stateReg)
            IDLE: begin
                ram1Addr = '0;
                if (memWrite) begin
                    stateNext = WR_SETUP;
                end else if (memRead) begin
                    stateNext = RD_SETUP;
                end
            end
            RD_SETUP: begin
                ram1EN    = 1'b0;
                ram1OE    = 1'b0;
                cntLoad   = 1'b1;
                stateNext = RD_WAIT;
            end
            RD_WAIT: begin
                ram1EN = 1'b0;
                ram1OE = 1'b0;
                if (cntZero) begin
                    stateNext = DONE;
                end else begin
                    cntDec = 1'b1;
                end
            end
            WR_SETUP: begin
                ram1EN    = 1'b0;
                busDrive  = 1'b1;
                cntLoad   = 1'b1;
                stateNext = WR_PULSE;
            end
            WR_PULSE: begin
                ram1EN   = 1'b0;
                ram1WE   = 1'b0;
                busDrive = 1'b1;
                if (cntZero) begin
                    stateNext = WR_HOLD;
                end else begin
                    cntDec = 1'b1;
                end
            end
            WR_HOLD: begin
                ram1EN    = 1'b0;
                busDrive  = 1'b1;
                stateNext = DONE;
            end
            DONE: begin
                memDone   = 1'b1;
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign memBusy  = accept || ((stateReg != IDLE) && (stateReg != DONE));
    assign dataOut  = dataOutReg;
    assign ram1Data = busDrive ? wrDataReg : {DATA_W{1'bz}};

endmodule

// File: tb/tb_ram1_bus_sequencer.sv
// Directed bench: two sequencers (WAIT_CYCLES 2 and 1), each with a cycle-sampled SRAM model.
module tb_ram1_bus_sequencer;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        loadMem = 1'b1;

    logic        memReadA = 0, memWriteA = 0, memReadB = 0, memWriteB = 0;
    logic [15:0] addressA = 0, dataInA = 0, addressB = 0, dataInB = 0;
    logic [15:0] dataOutA, dataOutB, ram1AddrA, ram1AddrB;
    logic        busyA, busyB, doneA, doneB;
    logic        enA, oeA, weA, enB, oeB, weB;
    wire  [15:0] ramDataA, ramDataB;
    logic        probeA = 0, probeB = 0;

    logic [15:0] memA [0:65535];
    logic [15:0] memB [0:65535];

    int checks = 0;
    int errors = 0;
    int violA = 0;
    int violB = 0;

    always #5 CLK = ~CLK;

    ram1_bus_sequencer #(.WAIT_CYCLES(2)) dutA (
        .CLK(CLK), .RST(RST), .memRead(memReadA), .memWrite(memWriteA),
        .address(addressA), .dataIn(dataInA), .dataOut(dataOutA),
        .memBusy(busyA), .memDone(doneA), .ram1EN(enA), .ram1OE(oeA),
        .ram1WE(weA), .ram1Addr(ram1AddrA), .ram1Data(ramDataA)
    );

    ram1_bus_sequencer #(.WAIT_CYCLES(1)) dutB (
        .CLK(CLK), .RST(RST), .memRead(memReadB), .memWrite(memWriteB),
        .address(addressB), .dataIn(dataInB), .dataOut(dataOutB),
        .memBusy(busyB), .memDone(doneB), .ram1EN(enB), .ram1OE(oeB),
        .ram1WE(weB), .ram1Addr(ram1AddrB), .ram1Data(ramDataB)
    );

    // SRAM models: drive on read, capture while WE low; a probe value exposes an undriven bus.
    assign ramDataA = (!enA && !oeA && weA) ? memA[ram1AddrA] : (probeA ? 16'hA5A5 : 16'hzzzz);
    assign ramDataB = (!enB && !oeB && weB) ? memB[ram1AddrB] : (probeB ? 16'hA5A5 : 16'hzzzz);

    always @(posedge CLK) begin
        if (loadMem) begin
            memA[16'h0040] <= 16'h1234;
            memB[16'h0040] <= 16'h1234;
        end else begin
            if (!enA && !weA) memA[ram1AddrA] <= ramDataA;
            if (!enB && !weB) memB[ram1AddrB] <= ramDataB;
        end
    end

    always @(negedge CLK) begin
        if (!oeA && !weA) violA <= violA + 1;
        if (!oeB && !weB) violB <= violB + 1;
    end

    logic        selDut = 0;
    wire         oeNow   = selDut ? oeB : oeA;
    wire         weNow   = selDut ? weB : weA;
    wire         busyNow = selDut ? busyB : busyA;
    wire         doneNow = selDut ? doneB : doneA;
    wire  [15:0] busNow  = selDut ? ramDataB : ramDataA;
    wire  [15:0] addrNow = selDut ? ram1AddrB : ram1AddrA;
    wire  [15:0] dOutNow = selDut ? dataOutB : dataOutA;

    logic [15:0] oeMask, weMask, busyMask, doneMask, busMask;
    logic        addrOk;
    int          doneCyc;

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic setReq(input bit sel, input bit rd, input bit wr,
                          input logic [15:0] a, input logic [15:0] d);
        if (sel) begin
            memReadB = rd; memWriteB = wr; addressB = a; dataInB = d;
        end else begin
            memReadA = rd; memWriteA = wr; addressA = a; dataInA = d;
        end
    endtask

    // Cycle 0 is the first cycle the request is visible; traces are bit-per-cycle masks.
    task automatic runAccess(input bit sel, input bit rd, input bit wr,
                             input logic [15:0] a, input logic [15:0] d, input bit scramble);
        oeMask = 0; weMask = 0; busyMask = 0; doneMask = 0; busMask = 0;
        addrOk = 1; doneCyc = -1;
        selDut = sel;
        @(posedge CLK); #1;
        setReq(sel, rd, wr, a, d);
        for (int c = 0; c < 16 && doneCyc < 0; c++) begin
            @(negedge CLK);
            oeMask[c]   = ~oeNow;
            weMask[c]   = ~weNow;
            busyMask[c] = busyNow;
            doneMask[c] = doneNow;
            busMask[c]  = (busNow === d);
            if (c >= 1 && addrNow !== a) addrOk = 0;
            if (scramble && c == 1) setReq(sel, rd, wr, ~a, ~d);
            if (scramble && c == 2) setReq(sel, 0, 0, ~a, ~d);
            if (doneNow) begin
                doneCyc = c;
                setReq(sel, 0, 0, 16'h0, 16'h0);
            end
        end
        if (doneCyc < 0) setReq(sel, 0, 0, 16'h0, 16'h0);
        $display("dut%s %s addr=%04h din=%04h doneCycle=%0d dataOut=%04h",
                 sel ? "B" : "A", wr ? "write" : "read ", a, d, doneCyc, dOutNow);
    endtask

    task automatic checkIdleBus(input bit sel, input string tag);
        @(negedge CLK);
        if (sel) probeB = 1; else probeA = 1;
        #1;
        checkValue({tag, "_busz"}, sel ? ramDataB : ramDataA, 16'hA5A5);
        checkValue({tag, "_addr0"}, sel ? ram1AddrB : ram1AddrA, 16'h0000);
        probeA = 0; probeB = 0;
    endtask

    initial begin
        bit sawDone;
        repeat (2) @(negedge CLK);
        probeA = 1; #1;
        checkValue("rst_ctrl", {enA, oeA, weA}, 3'b111);
        checkValue("rst_addr", ram1AddrA, 16'h0000);
        checkValue("rst_dout", dataOutA, 16'h0000);
        checkValue("rst_done_busy", {doneA, busyA}, 2'b00);
        checkValue("rst_busz", ramDataA, 16'hA5A5);
        probeA = 0;
        @(posedge CLK); #1;
        loadMem = 0;
        @(negedge CLK);
        RST = 1;

        // Read with mid-access operand change and early request drop
        runAccess(0, 1, 0, 16'h0040, 16'h0000, 1);
        checkValue("rd_oe", oeMask, 16'h000E);
        checkValue("rd_we", weMask, 16'h0000);
        checkValue("rd_busy", busyMask, 16'h000F);
        checkValue("rd_done", doneMask, 16'h0010);
        checkValue("rd_addr", addrOk, 1'b1);
        checkValue("rd_data", dataOutA, 16'h1234);
        checkIdleBus(0, "rd_idle");

        runAccess(0, 0, 1, 16'h0041, 16'hBEEF, 0);
        checkValue("wr_we", weMask, 16'h000C);
        checkValue("wr_oe", oeMask, 16'h0000);
        checkValue("wr_bus", busMask, 16'h001E);
        checkValue("wr_busy", busyMask, 16'h001F);
        checkValue("wr_done", doneMask, 16'h0020);
        checkValue("wr_addr", addrOk, 1'b1);
        checkValue("wr_mem", memA[16'h0041], 16'hBEEF);
        checkValue("wr_dout_hold", dataOutA, 16'h1234);
        checkIdleBus(0, "wr_idle");

        runAccess(0, 1, 1, 16'h0010, 16'h5555, 0);
        checkValue("both_oe", oeMask, 16'h0000);
        checkValue("both_we", weMask, 16'h000C);
        checkValue("both_done", doneMask, 16'h0020);
        checkValue("both_mem", memA[16'h0010], 16'h5555);
        checkValue("both_dout", dataOutA, 16'h1234);

        // Back-to-back: read request appears in the IDLE cycle right after DONE
        runAccess(0, 0, 1, 16'h0002, 16'h00AA, 0);
        checkValue("b2b_wr_done", doneMask, 16'h0020);
        runAccess(0, 1, 0, 16'h0002, 16'h0000, 0);
        checkValue("b2b_rd_busy", busyMask, 16'h000F);
        checkValue("b2b_rd_done", doneMask, 16'h0010);
        checkValue("b2b_rd_data", dataOutA, 16'h00AA);

        // Reset asserted during WR_PULSE
        selDut = 0;
        @(posedge CLK); #1;
        setReq(0, 0, 1, 16'h0040, 16'hDEAD);
        repeat (3) @(negedge CLK);
        checkValue("rstw_pulse_we", weA, 1'b0);
        RST = 0;
        probeA = 1; #1;
        checkValue("rstw_we", weA, 1'b1);
        checkValue("rstw_busz", ramDataA, 16'hA5A5);
        checkValue("rstw_done", doneA, 1'b0);
        probeA = 0;
        setReq(0, 0, 0, 16'h0, 16'h0);
        sawDone = 0;
        repeat (2) @(negedge CLK) sawDone |= doneA;
        RST = 1;
        repeat (4) @(negedge CLK) sawDone |= doneA;
        checkValue("rstw_nodone", sawDone, 1'b0);
        checkValue("rstw_dout0", dataOutA, 16'h0000);
        runAccess(0, 1, 0, 16'h0040, 16'h0000, 0);
        checkValue("rstw_rd_done", doneMask, 16'h0010);
        checkValue("rstw_rd_data", dataOutA, 16'h1234);

        // WAIT_CYCLES = 1 instance
        runAccess(1, 1, 0, 16'h0040, 16'h0000, 0);
        checkValue("w1_rd_oe", oeMask, 16'h0006);
        checkValue("w1_rd_done", doneMask, 16'h0008);
        checkValue("w1_rd_data", dataOutB, 16'h1234);
        runAccess(1, 0, 1, 16'h0050, 16'hCAFE, 0);
        checkValue("w1_wr_we", weMask, 16'h0004);
        checkValue("w1_wr_bus", busMask, 16'h000E);
        checkValue("w1_wr_done", doneMask, 16'h0010);
        checkValue("w1_wr_mem", memB[16'h0050], 16'hCAFE);
        checkIdleBus(1, "w1_idle");

        @(negedge CLK);
        checkValue("oe_we_overlap_a", violA, 0);
        checkValue("oe_we_overlap_b", violB, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram1_bus_sequencer.md
RAM1_BUS_SEQUENCER -- requirements
Module: ram1_bus_sequencer

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, SRAM access wait cycles (legal 1..15).
REQ-002 CLK  input  1  sole clock; all state changes on rising edge.
REQ-003 RST  input  1  reset, asynchronous and active-low.
REQ-004 memRead  input  1  read request from EX/MEM stage, level-held.
REQ-005 memWrite  input  1  write request from EX/MEM stage, level-held.
REQ-006 address  input  16  word address from EX/MEM ALU result.
REQ-007 dataIn  input  16  store data from EX/MEM.
REQ-008 dataOut  output  16  last captured read word, to MEM/WB.
REQ-009 memBusy  output  1  pipeline stall request, high while an access is pending.
REQ-010 memDone  output  1  one-cycle pulse, access complete.
REQ-011 ram1EN  output  1  SRAM chip enable, active-low.
REQ-012 ram1OE  output  1  SRAM output enable, active-low.
REQ-013 ram1WE  output  1  SRAM write enable, active-low.
REQ-014 ram1Addr  output  16  SRAM address.
REQ-015 ram1Data  inout  16  SRAM data bus, driven only during write states, else high-Z.

Function
REQ-016 States: IDLE, RD_SETUP, RD_WAIT, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
REQ-017 IDLE: memWrite=1 -> WR_SETUP; else memRead=1 -> RD_SETUP; else stay; address and dataIn latched on the accepting edge.
REQ-018 Simultaneous memRead and memWrite: write wins, read ignored.
REQ-019 memBusy = (state != IDLE and state != DONE) or (state == IDLE and (memRead or memWrite)); combinational.
REQ-020 Read: RD_SETUP 1 cycle (EN=0, OE=0, address driven) -> RD_WAIT WAIT_CYCLES cycles (EN=0, OE=0) -> DONE; ram1Data sampled into dataOut on the edge leaving RD_WAIT.
REQ-021 Write: WR_SETUP 1 cycle (EN=0, WE=1, data driven) -> WR_PULSE WAIT_CYCLES cycles (WE=0) -> WR_HOLD 1 cycle (WE=1, data and address held) -> DONE.
REQ-022 DONE: 1 cycle, memDone=1, memBusy=0, EN/OE/WE=1, bus high-Z; -> IDLE unconditionally.
REQ-023 Request latency (request-visible cycle 0): read memDone at cycle 2+WAIT_CYCLES; write at cycle 3+WAIT_CYCLES.
REQ-024 ram1Addr equals latched address in every non-IDLE state; in IDLE it is 0.
REQ-025 ram1OE and ram1WE never low in the same cycle; bus never driven while OE=0.
REQ-026 Request deassertion or address/dataIn change mid-access ignored; access completes on latched values.
REQ-027 Wait counter 4-bit, loaded WAIT_CYCLES-1 on entry to RD_WAIT/WR_PULSE, decrements, exit at 0; no wrap.
REQ-028 dataOut changes only at read capture; holds value across writes and idle.

Reset
REQ-029 RST low: immediately IDLE, ram1EN=ram1OE=ram1WE=1, ram1Data high-Z, ram1Addr=0, dataOut=0, memDone=0, counter=0.
REQ-030 Reset mid-access aborts it with no memDone; after release, requests accepted from the first edge.

Structure
REQ-031 Shared package holds state enum, WAIT_CYCLES default, ADDR_W=16, DATA_W=16.
REQ-032 One sub-module ram1_wait_counter (load, decrement, zero flag); FSM and tristate in the top.

Verification
REQ-033 Read: model holds 0x1234 at 0x0040, memRead=1 address=0x0040 -> OE low cycles 1-3, memDone cycle 4, dataOut=0x1234, memBusy high cycles 0-3.
REQ-034 Write: memWrite=1 address=0x0041 dataIn=0xBEEF -> WE low cycles 2-3 only, bus=0xBEEF cycles 1-4, memDone cycle 5, model[0x0041]=0xBEEF.
REQ-035 Both requests asserted, address=0x0010 dataIn=0x5555 -> write performed, OE never low, dataOut unchanged.
REQ-036 Back-to-back: write 0x00AA->0x0002 then read 0x0002 with no idle gap -> second access starts cycle after DONE, dataOut=0x00AA.
REQ-037 RST low during WR_PULSE -> WE=1 and bus high-Z same cycle, no memDone, next read of 0x0040 returns 0x1234.
REQ-038 WAIT_CYCLES=1: read latency 3 cycles, write latency 4 cycles, WE low exactly one cycle.
